circuit1_sweeper: RTL

CIRCUIT1_SWEEPER -- requirements
Module: circuit1_sweeper

---
 rtl/sweep_pkg.sv | 15 +
 rtl/sweep_vec_counter.sv | 44 ++++
 rtl/circuit1_sweeper.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sweep_pkg.sv
// Shared definitions for the circuit1 exhaustive truth-table sweeper.
package sweep_pkg;

    localparam int unsigned VEC_COUNT = 16;
    localparam int unsigned VEC_W     = 4;
    localparam int unsigned SETTLE_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/sweep_vec_counter.sv
// Vector index and settle-delay counter for the sweeper; exposes terminal-count flags.
import sweep_pkg::*;

module sweep_vec_counter #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             advance,
    input  logic             settle_tick,
    output logic [VEC_W-1:0] idx,
    output logic             settle_tc,
    output logic             idx_tc
);

    // The first vector gets one extra DRIVE cycle (the start-acceptance cycle),
    // so load uses the full count and each later vector reloads one less.
    localparam int unsigned RELOAD_I = (SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD   = SETTLE_W'(SETTLE_CYCLES);
    localparam logic [SETTLE_W-1:0] SETTLE_RELOAD = SETTLE_W'(RELOAD_I);

    logic [SETTLE_W-1:0] settle;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx    <= '0;
            settle <= '0;
        end else if (load) begin
            idx    <= '0;
            settle <= SETTLE_LOAD;
        end else if (advance) begin
            idx    <= idx + 1'b1;
            settle <= SETTLE_RELOAD;
        end else if (settle_tick && (settle != '0)) begin
            settle <= settle - 1'b1;
        end
    end

    assign settle_tc = (settle == '0);
    assign idx_tc    = (idx == VEC_W'(VEC_COUNT - 1));

endmodule

// File: rtl/circuit1_sweeper.sv
// Drives all 16 input vectors into a 4-input combinational DUT and captures its truth table.
// Optional complement check of dut_out_n is enabled by CIRCUIT1_COMPLEMENT_CHECK_EN.
import sweep_pkg::*;

module circuit1_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic                 a,
    output logic                 b,
    output logic                 c,
    output logic                 d,
    input  logic                 dut_out,
    input  logic                 dut_out_n,
    output logic                 busy,
    output logic                 done,
    output logic [VEC_COUNT-1:0] truth_table,
    output logic                 err,
    output logic [VEC_W-1:0]     err_index
);

    // With no settle time a vector goes straight from one SAMPLE to the next.
    localparam state_t NEXT_VEC = (SETTLE_CYCLES == 0) ? SAMPLE : DRIVE;

    state_t           state, state_n;
    logic [VEC_W-1:0] idx;
    logic             settle_tc, idx_tc;
    logic             cnt_clear, cnt_load, cnt_advance, cnt_tick;
    logic             accept, tt_we;

    sweep_vec_counter #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear      (cnt_clear),
        .load       (cnt_load),
        .advance    (cnt_advance),
        .settle_tick(cnt_tick),
        .idx        (idx),
        .settle_tc  (settle_tc),
        .idx_tc     (idx_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n     = state;
        cnt_clear   = 1'b0;
        cnt_load    = 1'b0;
        cnt_advance = 1'b0;
        cnt_tick    = 1'b0;
        accept      = 1'b0;
        tt_we       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_n  = DRIVE;
                    cnt_load = 1'b1;
                    accept   = 1'b1;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_n   = IDLE;
                    cnt_clear = 1'b1;
                end else if (settle_tc) begin
                    state_n = SAMPLE;
                end else begin
                    cnt_tick = 1'b1;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_n   = IDLE;
                    cnt_clear = 1'b1;
                end else begin
                    tt_we = 1'b1;
                    if (idx_tc) begin
                        state_n   = DONE;
                        cnt_clear = 1'b1;
                    end else begin
                        state_n     = NEXT_VEC;
                        cnt_advance = 1'b1;
                    end
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state == DRIVE) || (state == SAMPLE);
        done         = (state == DONE);
        {a, b, c, d} = busy ? idx : '0;
    end

    always_ff @(posedge clk) begin
        if (rst || accept) truth_table      <= '0;
        else if (tt_we)    truth_table[idx] <= dut_out;
    end

`ifdef CIRCUIT1_COMPLEMENT_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            err       <= 1'b0;
            err_index <= '0;
        end else if (tt_we && !err && (dut_out_n == dut_out)) begin
            err       <= 1'b1;
            err_index <= idx;
        end
    end
`else
    logic unused_dut_out_n;
    assign unused_dut_out_n = dut_out_n;
    assign err              = 1'b0;
    assign err_index        = '0;
`endif

endmodule
